// File: rtl/xoroshiro128_gen.sv
// xoroshiro128 family generator: configurable constants, +/++/** scramblers, seed load, valid/ready output.
// Define XORO_JUMP_EN to build the sequential 2^64-step jump engine (busy/jump_req); otherwise jump_req is ignored.
module xoroshiro128_gen #(
    parameter int unsigned A     = 55,
    parameter int unsigned B     = 14,
    parameter int unsigned C     = 36,
    parameter int unsigned MODE  = 0,
    parameter int unsigned R     = 17,
    parameter logic [63:0] SEED0 = 64'h1,
    parameter logic [63:0] SEED1 = 64'h0,
    parameter logic [63:0] JUMP0 = 64'hdf900294d8f554a5,
    parameter logic [63:0] JUMP1 = 64'h170865df4b3201fc
) (
    input  logic        clk,
    input  logic        res,
    input  logic        seed_valid,
    input  logic [63:0] seed_s0,
    input  logic [63:0] seed_s1,
    output logic        seed_ready,
    input  logic        jump_req,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out
);

    typedef enum logic [1:0] {PRIME, RUN, JUMP} state_t;

    state_t      state;
    logic [63:0] s0, s1;
    logic [127:0] nxt;
    logic        fire;
    logic        seed_acc;
    logic [63:0] ld_s0;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // One xoroshiro128 state transition, returned as {s1', s0'}
    function automatic logic [127:0] step_f(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] sx;
        sx = a ^ b;
        return {rotl(sx, C), rotl(a, A) ^ sx ^ (sx << B)};
    endfunction

    function automatic logic [63:0] scramble(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        case (MODE)
            1: scramble = rotl(a + b, R) + a;
            2: begin
                t = rotl((a << 2) + a, 7);
                scramble = (t << 3) + t;
            end
            default: scramble = a + b;
        endcase
    endfunction

    assign nxt      = step_f(s0, s1);
    assign fire     = out_valid & out_ready;
    assign seed_acc = seed_valid & seed_ready;
    // All-zero state would lock the generator; substitute s0=1
    assign ld_s0    = ((seed_s0 == 64'd0) && (seed_s1 == 64'd0)) ? 64'd1 : seed_s0;

`ifdef XORO_JUMP_EN
    localparam logic [127:0] JPOLY = {JUMP1, JUMP0};

    logic [63:0] acc0, acc1;
    logic [6:0]  k;
    logic        jbit;
    logic [63:0] acc0_n, acc1_n;

    assign jbit   = JPOLY[k];
    assign acc0_n = jbit ? (acc0 ^ s0) : acc0;
    assign acc1_n = jbit ? (acc1 ^ s1) : acc1;
`else
    logic unused_jump;
    assign unused_jump = jump_req ^ (^JUMP0) ^ (^JUMP1);
    assign busy        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= PRIME;
            s0         <= SEED0;
            s1         <= SEED1;
            out        <= 64'd0;
            out_valid  <= 1'b0;
            seed_ready <= 1'b0;
`ifdef XORO_JUMP_EN
            busy       <= 1'b0;
            acc0       <= 64'd0;
            acc1       <= 64'd0;
            k          <= 7'd0;
`endif
        end else begin
            case (state)
                PRIME: begin
                    out        <= scramble(s0, s1);
                    out_valid  <= 1'b1;
                    seed_ready <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    // Seed beats jump beats fire; losers are dropped
                    if (seed_acc) begin
                        s0         <= ld_s0;
                        s1         <= seed_s1;
                        out_valid  <= 1'b0;
                        seed_ready <= 1'b0;
                        state      <= PRIME;
                    end
`ifdef XORO_JUMP_EN
                    else if (jump_req) begin
                        acc0       <= 64'd0;
                        acc1       <= 64'd0;
                        k          <= 7'd0;
                        out_valid  <= 1'b0;
                        seed_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= JUMP;
                    end
`endif
                    else if (fire) begin
                        s0  <= nxt[63:0];
                        s1  <= nxt[127:64];
                        out <= scramble(nxt[63:0], nxt[127:64]);
                    end
                end
                JUMP: begin
`ifdef XORO_JUMP_EN
                    acc0 <= acc0_n;
                    acc1 <= acc1_n;
                    k    <= k + 7'd1;
                    if (k == 7'd127) begin
                        s0    <= acc0_n;
                        s1    <= acc1_n;
                        busy  <= 1'b0;
                        state <= PRIME;
                    end else begin
                        s0 <= nxt[63:0];
                        s1 <= nxt[127:64];
                    end
`else
                    state <= PRIME;
`endif
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_xoroshiro128_gen.sv
// Bench for xoroshiro128_gen: three instances (MODE 0/1/2) on shared stimulus, checked against an arithmetic model.
module tb_xoroshiro128_gen;

    logic        clk = 1'b0;
    logic        res, seed_valid, jump_req, out_ready;
    logic [63:0] seed_s0, seed_s1;
    logic        sr [3];
    logic        by [3];
    logic        ov [3];
    logic [63:0] ow [3];

    int tests = 0;
    int fails = 0;
    logic [63:0] m0, m1;

    always #5 clk = ~clk;

    xoroshiro128_gen #(.MODE(0)) u0 (.clk(clk), .res(res), .seed_valid(seed_valid), .seed_s0(seed_s0),
        .seed_s1(seed_s1), .seed_ready(sr[0]), .jump_req(jump_req), .busy(by[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out(ow[0]));
    xoroshiro128_gen #(.MODE(1)) u1 (.clk(clk), .res(res), .seed_valid(seed_valid), .seed_s0(seed_s0),
        .seed_s1(seed_s1), .seed_ready(sr[1]), .jump_req(jump_req), .busy(by[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out(ow[1]));
    xoroshiro128_gen #(.MODE(2)) u2 (.clk(clk), .res(res), .seed_valid(seed_valid), .seed_s0(seed_s0),
        .seed_s1(seed_s1), .seed_ready(sr[2]), .jump_req(jump_req), .busy(by[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .out(ow[2]));

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        logic [127:0] t;
        t = {x, x} << n;
        return t[127:64];
    endfunction

    function automatic logic [63:0] scr(input int mode, input logic [63:0] a, input logic [63:0] b);
        case (mode)
            1:       return rl(a + b, 17) + a;
            2:       return rl(a * 64'd5, 7) * 64'd9;
            default: return a + b;
        endcase
    endfunction

    task automatic m_step();
        logic [63:0] x;
        x  = m0 ^ m1;
        m0 = rl(m0, 55) ^ x ^ (x << 14);
        m1 = rl(x, 36);
    endtask

    // Reference jump(): xor-accumulate states selected by polynomial bits, low word first
    task automatic m_jump();
        logic [127:0] p;
        logic [63:0]  a0, a1;
        p  = {64'h170865df4b3201fc, 64'hdf900294d8f554a5};
        a0 = 64'd0;
        a1 = 64'd0;
        for (int b = 0; b < 128; b++) begin
            if (p[b]) begin
                a0 ^= m0;
                a1 ^= m1;
            end
            m_step();
        end
        m0 = a0;
        m1 = a1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic s, input logic b);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s/valid%0d", tag, i), 64'(ov[i]), 64'(v));
            chk($sformatf("%s/ready%0d", tag, i), 64'(sr[i]), 64'(s));
            chk($sformatf("%s/busy%0d", tag, i), 64'(by[i]), 64'(b));
            if (v) chk($sformatf("%s/out%0d", tag, i), ow[i], scr(i, m0, m1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        repeat (3) tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_out", ow[0], 64'd0);
        res = 1'b0;
        tick();
        m0 = 64'd1;
        m1 = 64'd0;
        chk_all("prime", 1'b1, 1'b1, 1'b0);
        chk("prime_out", ow[0], 64'h1);
    endtask

    // Random consumer backpressure; each accepted word advances the model by one step
    task automatic stream(input int n);
        logic r;
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            tick();
            if (r) m_step();
            chk_all("stream", 1'b1, 1'b1, 1'b0);
        end
        out_ready = 1'b0;
    endtask

    // Seed in RUN, then try (ignored) seed and jump during the PRIME cycle
    task automatic do_seed(input logic [63:0] a, input logic [63:0] b, input logic with_jump);
        seed_valid = 1'b1;
        seed_s0    = a;
        seed_s1    = b;
        jump_req   = with_jump;
        out_ready  = 1'($urandom_range(0, 1));
        tick();
        chk_all("seed_drop", 1'b0, 1'b0, 1'b0);
        seed_s0  = ~a;
        seed_s1  = b ^ 64'd1;
        jump_req = 1'b1;
        tick();
        seed_valid = 1'b0;
        jump_req   = 1'b0;
        out_ready  = 1'b0;
        if (a == 64'd0 && b == 64'd0) begin
            m0 = 64'd1;
            m1 = 64'd0;
        end else begin
            m0 = a;
            m1 = b;
        end
        chk_all("seed_prime", 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        res = 1'b1; seed_valid = 1'b0; jump_req = 1'b0; out_ready = 1'b0;
        seed_s0 = 64'd0; seed_s1 = 64'd0;
        do_reset();

        repeat (5) begin
            tick();
            chk_all("hold", 1'b1, 1'b1, 1'b0);
            chk("hold_out", ow[0], 64'h1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_step();
        chk_all("second", 1'b1, 1'b1, 1'b0);
        chk("second_out", ow[0], 64'h0080001000004001);

        stream(40);

        do_seed(64'd0, 64'd0, 1'b0);
        chk("zero_seed_out", ow[0], 64'h1);

        do_seed({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        repeat (3) begin
            tick();
            chk_all("seed_vs_jump", 1'b1, 1'b1, 1'b0);
        end

        do_seed(64'd1, 64'd2, 1'b0);
        chk("plus_12", ow[0], 64'h3);
        chk("plusplus_12", ow[1], 64'h60001);
        chk("starstar_12", ow[2], 64'h1680);

        for (int j = 0; j < 3; j++) begin
            do_seed({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            stream(25);
        end

`ifdef XORO_JUMP_EN
        begin
            int cnt;
            int lim;
            do_reset();
            out_ready = 1'b1;
            jump_req  = 1'b1;
            tick();
            jump_req  = 1'b0;
            out_ready = 1'b0;
            chk_all("jump_enter", 1'b0, 1'b0, 1'b1);
            cnt = 1;
            lim = 0;
            while (by[0] === 1'b1 && lim < 300) begin
                tick();
                lim++;
                if (by[0] === 1'b1) cnt++;
            end
            chk("jump_busy_cycles", 64'(cnt), 64'd128);
            chk_all("jump_done", 1'b0, 1'b0, 1'b0);
            tick();
            m_jump();
            chk_all("jump_word", 1'b1, 1'b1, 1'b0);
            stream(10);

            jump_req = 1'b1;
            tick();
            jump_req = 1'b0;
            repeat (50) tick();
            chk("midjump_busy", 64'(by[0]), 64'd1);
            do_reset();
        end
`else
        out_ready = 1'b1;
        jump_req  = 1'b1;
        tick();
        jump_req  = 1'b0;
        out_ready = 1'b0;
        m_step();
        chk_all("jump_ignored", 1'b1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xoroshiro128_gen.md
Name: xoroshiro128_gen

Overview:
Parametrised successor to the team's fixed xoroshiro128+ generator. It covers the xoroshiro128 family:
- selectable rotation/shift constants;
- three output scramblers (+, ++, **);
- runtime seed load;
- valid/ready output handshake;
- a sequential 2^64-step jump engine, so parallel consumers can take non-overlapping streams.

It sits between a seed/control source and any 64-bit random-number consumer.

Parameters:
A, 55, s0 rotate-left amount in the state update
B, 14, sx shift-left amount
C, 36, s1 rotate-left amount
MODE, 0, scrambler: 0 = plus (s0+s1), 1 = plusplus (rotl(s0+s1,R)+s0), 2 = starstar (rotl(s0*5,7)*9)
R, 17, rotate used by MODE 1
SEED0, 64'h1, s0 reset value
SEED1, 64'h0, s1 reset value
JUMP0, 64'hdf900294d8f554a5, jump polynomial low word
JUMP1, 64'h170865df4b3201fc, jump polynomial high word

Ports:
clk  in  1  clock, rising edge
res  in  1  synchronous reset, active-high
seed_valid  in  1  seed load request
seed_s0  in  64  new s0
seed_s1  in  64  new s1
seed_ready  out  1  seed accepted when high with seed_valid
jump_req  in  1  single-cycle jump request
busy  out  1  jump in progress
out_valid  out  1  out holds a valid word
out_ready  in  1  consumer accepts out
out  out  64  scrambled output word

Behaviour:
- Clock and reset: single clock clk; res is synchronous and active-high.
- Reset values: s0=SEED0, s1=SEED1, out=0, out_valid=0, busy=0, seed_ready=0, state=PRIME.
- Step function, all arithmetic mod 2^64:
  - sx = s0^s1
  - s0' = rotl(s0,A) ^ sx ^ (sx<<B)
  - s1' = rotl(sx,C)
- States:
  - PRIME: out <= scramble(s0,s1); out_valid <= 1; seed_ready <= 1; go to RUN. Takes one cycle.
  - RUN:
    - fire = out_valid & out_ready.
    - On fire: state <= step(state); out <= scramble(step(state)), registered, so the next word is visible the cycle after fire. Back-to-back fire gives one word per clock.
    - Without fire, out and out_valid hold stable.
  - JUMP:
    - On entry: acc0 = acc1 = 0; 7-bit counter k = 0; out_valid = 0; seed_ready = 0; busy = 1.
    - Each cycle: if bit k of {JUMP1,JUMP0} is set, acc ^= {s1,s0}; then state <= step(state); k++.
    - After k=127: {s1,s0} <= {acc1,acc0}; busy <= 0; go to PRIME.
    - Total 128 cycles plus 1 PRIME cycle before out_valid.
- Priority in RUN when events coincide: seed > jump > fire.
  - Seed accepted (seed_valid & seed_ready): load state and go to PRIME. out_valid drops for exactly one cycle, and any same-cycle fire is discarded (the state does not advance).
  - jump_req (no seed): go to JUMP; a same-cycle fire is discarded.
- All-zero seed (seed_s0 = seed_s1 = 0): load s0=1, s1=0 instead. The all-zero state is unreachable.
- In PRIME and JUMP, seed_valid and jump_req are ignored (not queued).
- res asserted during JUMP aborts the jump; all reset values apply on the next edge.
- MODE 2 multiplies: truncated to 64 bits; *5 and *9 may be done as shift-add.
- MODE is static; unsupported values behave as MODE 0.

Optional Feature:
XORO_JUMP_EN
- Defined: JUMP state, accumulator and counter present, as described above.
- Undefined: no jump logic; jump_req ignored; busy tied 0; RUN priority reduces to seed > fire.

Test Plan:
- Reset, MODE 0, defaults, out_ready=1 -> out_valid high 1 cycle after res release with out=64'h1; next word 64'h0080001000004001.
- out_ready held 0 for 5 cycles after the first word -> out stays 64'h1 and out_valid stays 1; then out_ready=1 -> 64'h0080001000004001.
- seed_valid with seed_s0=0, seed_s1=0 -> out_valid low 1 cycle, then out=64'h1 (forced s0=1).
- seed_valid and jump_req in the same RUN cycle -> seed wins, busy stays 0, out = scramble(seed).
- With XORO_JUMP_EN: jump_req after reset -> busy high 128 cycles, out_valid returns 1 cycle later, first word equals the C-model xoroshiro128+ jump() result from state (1,0). Pulse res mid-jump -> out_valid 1 cycle after release with out=64'h1.
- MODE 1 and MODE 2 with seed (1,2) -> first word matches the C reference for ++ / ** (MODE 2: rotl(5,7)*9 = 64'h1680).
